audio_frame_loader: RTL and testbench

//  Upstream sequencer for AudioProcessor. Accepts a 16-bit PCM sample stream (valid/ready).

---
 rtl/audio_pkg.sv | 35 +++
 rtl/audio_line_packer.sv | 55 +++++
 rtl/audio_frame_loader.sv | 197 +++++++++++++++++++
 tb/tb_audio_frame_loader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared sizes and the loader state type used by the audio frame loader and
// its line packer.
//   SAMPLE_W    bits per PCM sample
//   LINE_W      processor bus width
//   LANES       samples per line
//   LINES       lines per frame
//   IDX_W       line index width
//   LANE_W      lane index width
//   RD_LAT      cycles from output_index change to valid data_out
//   LAT_W       width of the read-latency counter
//   FRAME_CNT_W width of the completed-frame counter
// -----------------------------------------------------------------------------
package audio_pkg;

   localparam int SAMPLE_W    = 16;
   localparam int LINE_W      = 512;
   localparam int LANES       = LINE_W / SAMPLE_W;
   localparam int LINES       = 64;
   localparam int IDX_W       = $clog2(LINES);
   localparam int LANE_W      = $clog2(LANES);
   localparam int RD_LAT      = 1;
   localparam int LAT_W       = $clog2(RD_LAT + 1) + 1;
   localparam int FRAME_CNT_W = 16;

   typedef enum logic [2:0] {
      FILL,
      WRITE,
      START,
      WAIT,
      DRAIN
   } loader_state_t;

endpackage

// File: rtl/audio_line_packer.sv
// -----------------------------------------------------------------------------
// audio_line_packer
// Assembles LANES consecutive samples into one LINE_W line, lane 0 in the LSBs.
//   clk, rst  clock, asynchronous active-high reset
//   push      store sample in the current lane and advance the lane
//   sample    signed PCM sample
//   zero_pad  close the current line early; unfilled lanes stay zero
//   clear     empty the line and return to lane 0 (after it has been written)
//   line      assembled line
//   full      the line is complete at the end of this cycle
// -----------------------------------------------------------------------------
module audio_line_packer
   import audio_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic signed [SAMPLE_W-1:0] sample,
   input  logic                       zero_pad,
   input  logic                       clear,
   output logic [LINE_W-1:0]          line,
   output logic                       full
);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [LINE_W-1:0] line_q, line_d;

   // Lanes at or above the current lane are always zero because the line is
   // cleared after every write, so padding needs no extra data path.
   always_comb begin
      lane_d = lane_q;
      line_d = line_q;
      if (clear) begin
         lane_d = '0;
         line_d = '0;
      end else if (push) begin
         line_d[lane_q*SAMPLE_W +: SAMPLE_W] = sample;
         lane_d = lane_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q <= '0;
         line_q <= '0;
      end else begin
         lane_q <= lane_d;
         line_q <= line_d;
      end
   end

   assign line = line_q;
   assign full = zero_pad || (push && (lane_q == LANE_W'(LANES - 1)));

endmodule

// File: rtl/audio_frame_loader.sv
// -----------------------------------------------------------------------------
// audio_frame_loader
// Upstream sequencer for the audio processor: packs a sample stream into
// 512-bit lines, writes a 64-line frame, starts the processor, waits for done
// and streams the processed lines out.
//   clk, rst      clock, asynchronous active-high reset
//   s_valid/s_ready/s_data   sample input stream
//   flush         zero-pad the partial frame and process it
//   data_wr_en/input_index/data_in   processor line write port
//   start         one-cycle processor start pulse
//   done          processor done level (rising edge used)
//   output_index/data_out   processor read port
//   m_valid/m_ready/m_data/m_last   processed line output stream
//   busy          high outside FILL
//   frame_cnt     frames completed
// -----------------------------------------------------------------------------
module audio_frame_loader
   import audio_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic signed [SAMPLE_W-1:0] s_data,
   input  logic                       flush,
   output logic                       data_wr_en,
   output logic [IDX_W-1:0]           input_index,
   output logic [LINE_W-1:0]          data_in,
   output logic                       start,
   input  logic                       done,
   output logic [IDX_W-1:0]           output_index,
   input  logic [LINE_W-1:0]          data_out,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [LINE_W-1:0]          m_data,
   output logic                       m_last,
   output logic                       busy,
   output logic [FRAME_CNT_W-1:0]     frame_cnt
);

   loader_state_t          state_q, state_d;
   logic [IDX_W-1:0]       line_q, line_d;
   logic                   has_data_q, has_data_d;
   logic                   flush_pend_q, flush_pend_d;
   logic                   done_q;
   logic [LAT_W-1:0]       lat_q, lat_d;
   logic                   s_ready_q, s_ready_d;
   logic                   data_wr_en_q, data_wr_en_d;
   logic [IDX_W-1:0]       input_index_q, input_index_d;
   logic                   start_q, start_d;
   logic [IDX_W-1:0]       output_index_q, output_index_d;
   logic                   m_valid_q, m_valid_d;
   logic [LINE_W-1:0]      m_data_q, m_data_d;
   logic                   m_last_q, m_last_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic hs;
   logic done_rise;
   logic flush_go;
   logic pk_full;

   assign hs        = (state_q == FILL) && s_valid && s_ready_q;
   assign done_rise = done && !done_q;
   // A flush on an empty frame is dropped; a sample accepted in the same
   // cycle makes the frame non-empty.
   assign flush_go  = (state_q == FILL) && flush && (has_data_q || hs);

   audio_line_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .push     (hs),
      .sample   (s_data),
      .zero_pad (flush_go),
      .clear    (state_q == WRITE),
      .line     (data_in),
      .full     (pk_full)
   );

   always_comb begin
      state_d        = state_q;
      line_d         = line_q;
      has_data_d     = has_data_q;
      flush_pend_d   = flush_pend_q;
      lat_d          = lat_q;
      output_index_d = output_index_q;
      m_valid_d      = m_valid_q;
      m_data_d       = m_data_q;
      m_last_d       = m_last_q;
      frame_cnt_d    = frame_cnt_q;

      case (state_q)
         FILL: begin
            if (hs) has_data_d = 1'b1;
            if (flush_go) flush_pend_d = 1'b1;
            if (pk_full) state_d = WRITE;
         end
         WRITE: begin
            // line wraps 63 -> 0, leaving the next frame at line 0
            line_d = line_q + 1'b1;
            if (line_q == IDX_W'(LINES - 1)) begin
               state_d      = START;
               flush_pend_d = 1'b0;
               has_data_d   = 1'b0;
            end else if (flush_pend_q) begin
               state_d = WRITE;
            end else begin
               state_d = FILL;
            end
         end
         START: state_d = WAIT;
         WAIT: begin
            if (done_rise) begin
               state_d        = DRAIN;
               output_index_d = '0;
               lat_d          = '0;
            end
         end
         DRAIN: begin
            if (!m_valid_q) begin
               if (lat_q == LAT_W'(RD_LAT)) begin
                  m_valid_d = 1'b1;
                  m_data_d  = data_out;
                  m_last_d  = (output_index_q == IDX_W'(LINES - 1));
               end else begin
                  lat_d = lat_q + 1'b1;
               end
            end else if (m_ready) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (m_last_q) begin
                  state_d     = FILL;
                  frame_cnt_d = frame_cnt_q + 1'b1;
                  line_d      = '0;
               end else begin
                  output_index_d = output_index_q + 1'b1;
                  lat_d          = '0;
               end
            end
         end
         default: state_d = FILL;
      endcase

      // Handshake/strobe outputs are registered, so they follow the next state.
      s_ready_d     = (state_d == FILL);
      data_wr_en_d  = (state_d == WRITE);
      input_index_d = (state_d == WRITE) ? line_d : '0;
      start_d       = (state_d == START);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= FILL;
         line_q         <= '0;
         has_data_q     <= 1'b0;
         flush_pend_q   <= 1'b0;
         done_q         <= 1'b0;
         lat_q          <= '0;
         s_ready_q      <= 1'b0;
         data_wr_en_q   <= 1'b0;
         input_index_q  <= '0;
         start_q        <= 1'b0;
         output_index_q <= '0;
         m_valid_q      <= 1'b0;
         m_data_q       <= '0;
         m_last_q       <= 1'b0;
         frame_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         line_q         <= line_d;
         has_data_q     <= has_data_d;
         flush_pend_q   <= flush_pend_d;
         done_q         <= done;
         lat_q          <= lat_d;
         s_ready_q      <= s_ready_d;
         data_wr_en_q   <= data_wr_en_d;
         input_index_q  <= input_index_d;
         start_q        <= start_d;
         output_index_q <= output_index_d;
         m_valid_q      <= m_valid_d;
         m_data_q       <= m_data_d;
         m_last_q       <= m_last_d;
         frame_cnt_q    <= frame_cnt_d;
      end
   end

   assign s_ready      = s_ready_q;
   assign data_wr_en   = data_wr_en_q;
   assign input_index  = input_index_q;
   assign start        = start_q;
   assign output_index = output_index_q;
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_last       = m_last_q;
   assign busy         = (state_q != FILL);
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_audio_frame_loader.sv
module tb_audio_frame_loader;
   import audio_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst, s_valid, flush, m_ready, done;
   logic signed [15:0] s_data;
   logic               s_ready, data_wr_en, start, m_valid, m_last, busy;
   logic [5:0]         input_index, output_index;
   logic [511:0]       data_in, data_out, m_data;
   logic [15:0]        frame_cnt;

   audio_frame_loader dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .flush(flush), .data_wr_en(data_wr_en), .input_index(input_index), .data_in(data_in),
      .start(start), .done(done), .output_index(output_index), .data_out(data_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   // processor loopback: line store with one cycle read latency
   logic [511:0] mem [64];
   always @(posedge clk) begin
      if (data_wr_en) mem[input_index] <= data_in;
      data_out <= mem[output_index];
   end

   // done rises 100 cycles after start when auto_en, falls on the next start
   logic auto_en = 1'b1, done_auto = 1'b0, done_man = 1'b0;
   int   dcnt = 0;
   always @(posedge clk) begin
      if (start) begin
         dcnt      <= 100;
         done_auto <= 1'b0;
      end else if (!auto_en) begin
         dcnt      <= 0;
         done_auto <= 1'b0;
      end else if (dcnt != 0) begin
         dcnt <= dcnt - 1;
         if (dcnt == 1) done_auto <= 1'b1;
      end
   end
   assign done = done_auto | done_man;

   // m_ready: manual level, or accept on the third cycle of every valid beat
   logic mr_mode = 1'b0, mr_man = 1'b0;
   int   ph = 0;
   always @(posedge clk) begin
      if (m_valid && m_ready) ph <= 0;
      else if (m_valid) ph <= ph + 1;
   end
   assign m_ready = mr_mode ? (ph == 2) : mr_man;

   // event monitor
   int           wr_cnt = 0, start_cnt = 0, beat_cnt = 0, unstable = 0;
   int           sr_busy = 0, both_cnt = 0, order_err = 0;
   logic [5:0]   exp_idx = 6'd0;
   logic [511:0] beat_data [512];
   logic         beat_last [512];
   logic         prev_mv = 1'b0, prev_mr = 1'b0;
   logic [511:0] prev_md = '0;
   always @(posedge clk) begin
      if (rst) exp_idx <= 6'd0;
      else if (data_wr_en) begin
         if (input_index !== exp_idx) order_err <= order_err + 1;
         exp_idx <= exp_idx + 6'd1;
      end
      if (data_wr_en) wr_cnt <= wr_cnt + 1;
      if (start) start_cnt <= start_cnt + 1;
      if (data_wr_en && start) both_cnt <= both_cnt + 1;
      if (busy && s_ready) sr_busy <= sr_busy + 1;
      if (m_valid && m_ready) begin
         if (beat_cnt < 512) begin
            beat_data[beat_cnt] <= m_data;
            beat_last[beat_cnt] <= m_last;
         end
         beat_cnt <= beat_cnt + 1;
      end
      if (prev_mv && !prev_mr && (!m_valid || m_data !== prev_md)) unstable <= unstable + 1;
      prev_mv <= m_valid;
      prev_mr <= m_ready;
      prev_md <= m_data;
   end

   int n_cmp = 0, n_bad = 0;
   int push_ticks = 0;
   int w0, s0, b0, u0, sb0;
   logic [511:0] exp_line [64];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [15:0] gen(input int i, input int mul, input int add);
      return 16'(i * mul + add);
   endfunction

   task automatic build_exp(input int mul, input int add, input int nsamp);
      for (int l = 0; l < 64; l++) begin
         exp_line[l] = '0;
         for (int k = 0; k < 32; k++)
            if (l * 32 + k < nsamp) exp_line[l][16*k +: 16] = gen(l * 32 + k, mul, add);
      end
   endtask

   task automatic push(input logic [15:0] v);
      int g = 0;
      s_valid = 1'b1;
      s_data  = v;
      while (!s_ready && g < 50) begin
         tick();
         g++;
         push_ticks++;
      end
      if (g >= 50) chk_b("s_ready_wait", s_ready, 1'b1);
      tick();
      push_ticks++;
   endtask

   task automatic send(input int mul, input int add, input int first, input int n);
      for (int i = first; i < first + n; i++) push(gen(i, mul, add));
      s_valid = 1'b0;
   endtask

   task automatic wait_frames(input logic [15:0] v, input string tag);
      int g = 0;
      while (frame_cnt !== v && g < 2000) begin
         tick();
         g++;
      end
      chk(tag, 512'(frame_cnt), 512'(v));
   endtask

   task automatic check_mem(input string tag);
      int bad = 0;
      for (int l = 0; l < 64; l++) if (mem[l] !== exp_line[l]) bad++;
      chk_i(tag, bad, 0);
   endtask

   task automatic check_beats(input int base, input string tag);
      int bad = 0, lastbad = 0;
      chk_i({tag, "_beats"}, beat_cnt - base, 64);
      for (int k = 0; k < 64; k++) begin
         if (beat_data[base + k] !== exp_line[k]) bad++;
         if (beat_last[base + k] !== (k == 63)) lastbad++;
      end
      chk_i({tag, "_data"}, bad, 0);
      chk_i({tag, "_last"}, lastbad, 0);
   endtask

   task automatic check_idle(input string tag);
      chk_b({tag, "_s_ready"}, s_ready, 1'b0);
      chk_b({tag, "_wr_en"}, data_wr_en, 1'b0);
      chk_b({tag, "_start"}, start, 1'b0);
      chk_b({tag, "_m_valid"}, m_valid, 1'b0);
      chk_b({tag, "_m_last"}, m_last, 1'b0);
      chk_b({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_frame_cnt"}, 512'(frame_cnt), 512'(0));
      chk({tag, "_in_idx"}, 512'(input_index), 512'(0));
      chk({tag, "_out_idx"}, 512'(output_index), 512'(0));
      chk({tag, "_data_in"}, data_in, 512'(0));
      chk({tag, "_m_data"}, m_data, 512'(0));
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; flush = 1'b0;
      tick(3);
      check_idle("rst");
      rst = 1'b0;
      tick();
      chk_b("s_ready_after_rst", s_ready, 1'b1);

      // 1) ramp frame fill
      build_exp(1, 0, 2048);
      w0 = wr_cnt; s0 = start_cnt; push_ticks = 0;
      send(1, 0, 0, 2048);
      chk_i("fill_cycles", push_ticks, 2111);
      tick(3);
      chk_i("t1_writes", wr_cnt - w0, 64);
      chk_i("t1_start", start_cnt - s0, 1);
      chk("t1_line0_lane0", 512'(mem[0][15:0]), 512'(0));
      chk("t1_line0_lane31", 512'(mem[0][511:496]), 512'(31));
      chk("t1_line63_lane0", 512'(mem[63][15:0]), 512'(2016));
      chk("t1_line63_lane31", 512'(mem[63][511:496]), 512'(2047));
      check_mem("t1_mem");
      chk_b("t1_busy", busy, 1'b1);

      // 2) loopback drain, m_ready held high
      b0 = beat_cnt; mr_man = 1'b1;
      wait_frames(16'd1, "t2_frame_cnt");
      check_beats(b0, "t2");
      chk_b("t2_s_ready", s_ready, 1'b1);
      chk_b("t2_busy", busy, 1'b0);

      // 3) stalled drain, m_ready one cycle in three
      build_exp(7, 42405, 2048);
      mr_man = 1'b0; mr_mode = 1'b1;
      u0 = unstable; sb0 = sr_busy; b0 = beat_cnt;
      send(7, 42405, 0, 2048);
      wait_frames(16'd2, "t3_frame_cnt");
      check_beats(b0, "t3");
      chk_i("t3_stable", unstable - u0, 0);
      chk_i("t3_s_ready_busy", sr_busy - sb0, 0);
      mr_mode = 1'b0; mr_man = 1'b1;

      // 4) flush on an empty frame, then 40 samples with flush on the last
      w0 = wr_cnt;
      flush = 1'b1; tick(); flush = 1'b0;
      tick(4);
      chk_i("t4_empty_flush_writes", wr_cnt - w0, 0);
      chk_b("t4_empty_flush_busy", busy, 1'b0);
      build_exp(3, 1000, 40);
      s0 = start_cnt; b0 = beat_cnt;
      send(3, 1000, 0, 39);
      chk_b("t4_s_ready_at_flush", s_ready, 1'b1);
      s_valid = 1'b1; s_data = gen(39, 3, 1000); flush = 1'b1;
      tick();
      s_valid = 1'b0; flush = 1'b0;
      for (int g = 0; g < 300 && start_cnt == s0; g++) tick();
      tick();
      chk_i("t4_start", start_cnt - s0, 1);
      chk_i("t4_writes", wr_cnt - w0, 64);
      chk("t4_line1_lane7", 512'(mem[1][127:112]), 512'(1117));
      chk("t4_line1_lane8", 512'(mem[1][143:128]), 512'(0));
      check_mem("t4_mem");
      wait_frames(16'd3, "t4_frame_cnt");
      check_beats(b0, "t4");

      // 5) reset while waiting for done
      auto_en = 1'b0;
      send(5, 77, 0, 2048);
      tick(8);
      chk_b("t5_waiting", busy, 1'b1);
      rst = 1'b1;
      tick();
      check_idle("t5_rst");
      rst = 1'b0;
      tick();
      b0 = beat_cnt;
      done_man = 1'b1; tick(3);
      chk_b("t5_done_in_fill_busy", busy, 1'b0);
      chk_i("t5_done_in_fill_beats", beat_cnt - b0, 0);
      done_man = 1'b0; tick();
      auto_en = 1'b1;
      build_exp(9, 5000, 2048);
      w0 = wr_cnt;
      send(9, 5000, 0, 32);
      chk_b("t5_first_wr_en", data_wr_en, 1'b1);
      chk("t5_first_idx", 512'(input_index), 512'(0));
      chk("t5_first_data", data_in, exp_line[0]);
      send(9, 5000, 32, 2016);
      wait_frames(16'd1, "t5_frame_cnt");
      check_beats(b0, "t5");
      chk_i("t5_writes", wr_cnt - w0, 64);

      // 6) done held high across two frames, pulse during FILL
      auto_en = 1'b0;
      done_man = 1'b1; tick(2);
      chk_b("t6_fill_busy", busy, 1'b0);
      chk_b("t6_fill_s_ready", s_ready, 1'b1);
      build_exp(11, 3, 2048);
      b0 = beat_cnt;
      send(11, 3, 0, 2048);
      tick(53);
      chk_b("t6a_held_wait", busy, 1'b1);
      chk_i("t6a_held_beats", beat_cnt - b0, 0);
      done_man = 1'b0; tick(); done_man = 1'b1;
      wait_frames(16'd2, "t6a_frame_cnt");
      check_beats(b0, "t6a");
      done_man = 1'b0; tick(); done_man = 1'b1; tick();
      chk_b("t6_pulse_fill_busy", busy, 1'b0);
      build_exp(13, 9, 2048);
      b0 = beat_cnt;
      send(13, 9, 0, 2048);
      tick(53);
      chk_b("t6b_held_wait", busy, 1'b1);
      chk_i("t6b_held_beats", beat_cnt - b0, 0);
      chk("t6b_frame_cnt_held", 512'(frame_cnt), 512'(2));
      done_man = 1'b0; tick(); done_man = 1'b1;
      wait_frames(16'd3, "t6b_frame_cnt");
      check_beats(b0, "t6b");

      chk_i("wr_order", order_err, 0);
      chk_i("wr_start_overlap", both_cnt, 0);
      chk_i("s_ready_while_busy", sr_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
